kbd_rx: RTL

- Keyboard input stage between the FT245 receive side and the 6821 PIA port A (keyboard port) of the Apple-1 mini.
- Reads bytes from the FT245 with correct RD# timing and filters them into Apple-1 keyboard codes.
- Buffers the codes in a small FIFO and presents them one at a time on PA[6:0] with a CA1 strobe.
- Pops a code when the CPU reads port A (E and CA2 both high).

---
 rtl/kbd_rx_pkg.sv | 28 ++
 rtl/kbd_rx_if.sv | 23 ++
 rtl/kbd_rx_buf.sv | 57 +++++
 rtl/kbd_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_rx_pkg.sv
// kbd_rx_pkg: shared ASCII constants and FSM state encodings for the keyboard stage.
// Latency: none (definitions only).
// Backpressure: n/a.
package kbd_rx_pkg;

  // Codes the filter treats specially (7-bit, after bit 7 is stripped).
  localparam logic [6:0] ASCII_BS     = 7'h08;
  localparam logic [6:0] ASCII_LF     = 7'h0A;
  localparam logic [6:0] ASCII_DEL    = 7'h7F;
  localparam logic [6:0] ASCII_RUBOUT = 7'h5F;  // Apple-1 '_' rubout
  localparam logic [6:0] LOWER_A      = 7'h61;
  localparam logic [6:0] LOWER_Z      = 7'h7A;

  // FT245 read sequencer.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOW  = 2'd1,
    R_REC  = 2'd2
  } rd_state_e;

  // PIA presentation sequencer.
  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_STROBE = 2'd1,
    P_GAP    = 2'd2
  } pr_state_e;

endpackage

// File: rtl/kbd_rx_if.sv
// kbd_rx_if: FT245 receive pins plus PIA port-A keyboard pins in one bundle.
// Latency: none (wires only).
// Backpressure: FT245 side paced by RXF#/RD#, PIA side by CA1 strobe / E&CA2 read ack.
// master = board side (FT245 + PIA), slave = kbd_rx.
interface kbd_rx_if;
  logic       fifo_rxf;   // FT245 RXF#, low = byte available
  logic       fifo_rd;    // FT245 RD#, active low
  logic [7:0] fifo_data;  // FT245 D[7:0]
  logic       pia_e;      // PIA E clock
  logic       pia_ca2;    // PIA CA2 read acknowledge
  logic [6:0] pia_pa;     // keyboard code to PA[6:0]
  logic       pia_ca1;    // keyboard strobe, PIA latches on rising edge

  modport master (
    output fifo_rxf, fifo_data, pia_e, pia_ca2,
    input  fifo_rd, pia_pa, pia_ca1
  );

  modport slave (
    input  fifo_rxf, fifo_data, pia_e, pia_ca2,
    output fifo_rd, pia_pa, pia_ca1
  );
endinterface

// File: rtl/kbd_rx_buf.sv
// kbd_buf: DEPTH x W circular buffer, head always visible on head_o.
// Latency: push visible on head/count the cycle after; pop advances head next cycle.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
// Ports: clk, rst_n, push_i/push_dat_i, pop_i, head_o, count_o (0..DEPTH), full_o, empty_o.
module kbd_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kbd_rx.sv
// kbd_rx: FT245 byte reader -> Apple-1 key filter -> buffer -> PIA port A with CA1 strobe.
// Latency: RXF# fall to RD# low 3 clk; byte sample to CA1 rise 3 clk with an empty buffer.
// Backpressure: no FT245 read while the buffer is full; codes pop only on a PIA read (E & CA2).
// Ports: clk, reset (async active low), bus (kbd_rx_if.slave: FT245 RXF#/RD#/D, PIA E/CA2/PA/CA1).
module kbd_rx
  import kbd_rx_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RD_CYCLES  = 2,
  parameter int RD_RECOVER = 3,
  parameter int GAP_CYCLES = 2,
  parameter bit UPCASE     = 1'b1,
  parameter bit DROP_LF    = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  kbd_rx_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- synchronizers ----------------
  logic [1:0] rxf_sync_q, e_sync_q, ca2_sync_q;
  logic       rdack_q;
  logic       rdack, ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxf_sync_q <= 2'b11;   // idle RXF# is high: nothing to read
      e_sync_q   <= 2'b00;
      ca2_sync_q <= 2'b00;
      rdack_q    <= 1'b0;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], bus.fifo_rxf};
      e_sync_q   <= {e_sync_q[0],   bus.pia_e};
      ca2_sync_q <= {ca2_sync_q[0], bus.pia_ca2};
      rdack_q    <= rdack;
    end
  end

  // One-clk pulse on the rising edge of the CPU port-A read.
  assign rdack = e_sync_q[1] & ca2_sync_q[1];
  assign ack   = rdack & ~rdack_q;

  // ---------------- buffer ----------------
  logic          buf_push, buf_pop, buf_full, buf_empty;
  logic [6:0]    buf_head, flt_code;
  logic [CW-1:0] buf_count;

  kbd_buf #(.DEPTH(DEPTH), .W(7)) u_buf (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (buf_push),
    .push_dat_i (flt_code),
    .pop_i      (buf_pop),
    .head_o     (buf_head),
    .count_o    (buf_count),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  // ---------------- FT245 read FSM ----------------
  rd_state_e  rd_state_q;
  logic [7:0] rd_cnt_q;
  logic       fifo_rd_q;
  logic [6:0] rx_byte_q;   // bit 7 is never used by the filter
  logic       rx_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      fifo_rd_q  <= 1'b1;
      rx_byte_q  <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      case (rd_state_q)
        R_IDLE: begin
          // A full buffer leaves RXF# pending; the byte stays in the FT245.
          if (!rxf_sync_q[1] && !buf_full) begin
            rd_state_q <= R_LOW;
            fifo_rd_q  <= 1'b0;
            rd_cnt_q   <= '0;
          end
        end
        R_LOW: begin
          if (rd_cnt_q == 8'(RD_CYCLES - 1)) begin
            rx_byte_q  <= bus.fifo_data[6:0];  // sampled while RD# is still low
            rx_vld_q   <= 1'b1;
            fifo_rd_q  <= 1'b1;
            rd_cnt_q   <= '0;
            rd_state_q <= R_REC;
          end else begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
          end
        end
        R_REC: begin
          // Gives the FT245 time to update RXF# and the sync chain to follow.
          if (rd_cnt_q == 8'(RD_RECOVER - 1)) begin
            rd_cnt_q   <= '0;
            rd_state_q <= R_IDLE;
          end else begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          fifo_rd_q  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- key filter ----------------
  logic flt_keep;

  always_comb begin
    flt_code = rx_byte_q;
    flt_keep = 1'b1;
    if (UPCASE && rx_byte_q >= LOWER_A && rx_byte_q <= LOWER_Z) begin
      flt_code = rx_byte_q - 7'h20;
    end else if (rx_byte_q == ASCII_BS || rx_byte_q == ASCII_DEL) begin
      flt_code = ASCII_RUBOUT;
    end else if (DROP_LF && rx_byte_q == ASCII_LF) begin
      flt_keep = 1'b0;
    end
  end

  // The push lands the cycle after the sample, well inside R_REC, so the
  // full check in R_IDLE always sees the updated count.
  assign buf_push = rx_vld_q & flt_keep;

  // ---------------- PIA presentation FSM ----------------
  pr_state_e  pr_state_q;
  logic [7:0] gap_cnt_q;
  logic       ca1_q;
  logic [6:0] pa_q;

  assign buf_pop = (pr_state_q == P_STROBE) && ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr_state_q <= P_IDLE;
      gap_cnt_q  <= '0;
      ca1_q      <= 1'b0;
      pa_q       <= '0;
    end else begin
      case (pr_state_q)
        P_IDLE: begin
          ca1_q <= 1'b0;
          if (!buf_empty) begin
            pa_q       <= buf_head;  // PA settles one clk before CA1 rises
            pr_state_q <= P_STROBE;
          end
        end
        P_STROBE: begin
          if (ack) begin
            ca1_q      <= 1'b0;
            gap_cnt_q  <= '0;
            pr_state_q <= P_GAP;
          end else begin
            ca1_q <= 1'b1;
          end
        end
        P_GAP: begin
          ca1_q <= 1'b0;
          if (gap_cnt_q == 8'(GAP_CYCLES - 1)) begin
            if (buf_count != '0) begin
              pa_q       <= buf_head;
              pr_state_q <= P_STROBE;
            end else begin
              pr_state_q <= P_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          ca1_q      <= 1'b0;
          pr_state_q <= P_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd = fifo_rd_q;
  assign bus.pia_ca1 = ca1_q;
  assign bus.pia_pa  = pa_q;

endmodule
